// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: latch commands, hazard-controller FSM states and
// the bundled per-cycle latch/PC command.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hctl_state_t;

  typedef struct packed {
    pipe_state_t fd;
    pipe_state_t de;
    pipe_state_t em;
    pipe_state_t mw;
    logic        pc_en;
  } latch_cmd_t;

  function automatic latch_cmd_t make_cmd(pipe_state_t fd, pipe_state_t de,
                                          pipe_state_t em, pipe_state_t mw,
                                          logic pc_en);
    latch_cmd_t c;
    c.fd    = fd;
    c.de    = de;
    c.em    = em;
    c.mw    = mw;
    c.pc_en = pc_en;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the hazard controller (slave) and the pipeline datapath (master).
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 32,
    parameter int REG_W = cpu_types_pkg::REG_W
);
    import cpu_types_pkg::*;

    logic             ihit;
    logic             dhit;
    logic             dREN_mem;
    logic             dWEN_mem;
    logic             MemRead_ex;
    logic [REG_W-1:0] regWSEL_ex;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             uses_rt_id;
    logic             pc_redirect_mem;
    logic             halt_wb;
    pipe_state_t      fd_state;
    pipe_state_t      de_state;
    pipe_state_t      em_state;
    pipe_state_t      mw_state;
    logic             pc_en;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, dREN_mem, dWEN_mem, MemRead_ex, regWSEL_ex,
               rs_id, rt_id, uses_rt_id, pc_redirect_mem, halt_wb,
        input  fd_state, de_state, em_state, mw_state, pc_en, halt,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, dREN_mem, dWEN_mem, MemRead_ex, regWSEL_ex,
               rs_id, rt_id, uses_rt_id, pc_redirect_mem, halt_wb,
        output fd_state, de_state, em_state, mw_state, pc_en, halt,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_perf_counters.sv
// Stall and flush performance counters; both wrap and hold while frozen.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    input  logic             freeze_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (!freeze_i) begin
            if (stall_inc_i) stall_q <= stall_q + CNT_W'(1);
            if (flush_inc_i) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central pipeline sequencer: per-cycle latch commands and PC enable from
// data waits, fetch misses, load-use hazards, redirects and halt drain.
module pipeline_hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = cpu_types_pkg::REG_W
) (
    input  logic                         CLK,
    input  logic                         RST,
    pipeline_hazard_controller_if.slave  bus
);
    hctl_state_t      state_q, state_d;
    logic             halt_q;
    latch_cmd_t       cmd;
    logic             resolve, flush_inc;
    logic             mem_busy, load_use;
    logic [REG_W-1:0] wsel;

    assign wsel     = bus.regWSEL_ex;
    assign mem_busy = (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit;
    assign load_use = bus.MemRead_ex && (wsel != '0) &&
                      ((wsel == bus.rs_id) || (bus.uses_rt_id && (wsel == bus.rt_id)));

    // RUN and a completing DWAIT share the redirect/load-use/fetch rules via 'resolve'.
    always_comb begin
        state_d   = state_q;
        resolve   = 1'b0;
        flush_inc = 1'b0;
        cmd       = make_cmd(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
        unique case (state_q)
            RUN: begin
                if (bus.halt_wb)   state_d = HALT;
                else if (mem_busy) state_d = DWAIT;
                else               resolve = 1'b1;
            end
            DWAIT: begin
                if (bus.halt_wb) state_d = HALT;
                else if (bus.dhit) begin
                    state_d = RUN;
                    resolve = 1'b1;
                end
            end
            HALT: state_d = HALT;
            default: state_d = RUN;
        endcase

        if (resolve) begin
            if (bus.pc_redirect_mem) begin
                cmd       = make_cmd(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b1);
                flush_inc = 1'b1;
            end else if (load_use)
                cmd = make_cmd(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
            else if (!bus.ihit)
                cmd = make_cmd(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
            else
                cmd = make_cmd(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_q || (state_d == HALT);
        end
    end

    hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk_i       (CLK),
        .rst_i       (RST),
        .stall_inc_i (!cmd.pc_en && (state_d != HALT)),
        .flush_inc_i (flush_inc),
        .freeze_i    (state_q == HALT),
        .stall_cnt_o (bus.stall_cnt),
        .flush_cnt_o (bus.flush_cnt)
    );

    assign bus.fd_state = cmd.fd;
    assign bus.de_state = cmd.de;
    assign bus.em_state = cmd.em;
    assign bus.mw_state = cmd.mw;
    assign bus.pc_en    = cmd.pc_en;
    assign bus.halt     = halt_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed plus randomized checks of pipeline_hazard_controller against a rule-level model.
module tb_pipeline_hazard_controller;
    localparam int CW = 32;
    localparam logic [1:0] E = 2'd0, S = 2'd1, N = 2'd2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_controller_if #(.CNT_W(CW), .REG_W(5)) bus ();
    pipeline_hazard_controller #(.CNT_W(CW), .REG_W(5)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    // Model: mode 0=running, 1=waiting on data, 2=halted
    int          mode;
    logic        m_halt;
    logic [CW-1:0] m_stall, m_flush;
    logic [1:0]  e_fd, e_de, e_em, e_mw;
    logic        e_pc, e_flush;
    int          e_next;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [1:0] v, input logic pc);
        e_fd = v; e_de = v; e_em = v; e_mw = v; e_pc = pc;
    endtask

    task automatic eval_model();
        logic lu;
        e_flush = 1'b0;
        lu = bus.MemRead_ex && bus.regWSEL_ex != 0 &&
             (bus.regWSEL_ex == bus.rs_id || (bus.uses_rt_id && bus.regWSEL_ex == bus.rt_id));
        set_all(S, 1'b0);
        e_next = mode;
        if (mode == 2) e_next = 2;
        else if (bus.halt_wb) e_next = 2;
        else if (mode == 1 && !bus.dhit) e_next = 1;
        else if (mode == 0 && (bus.dREN_mem || bus.dWEN_mem) && !bus.dhit) e_next = 1;
        else begin
            e_next = 0;
            if (bus.pc_redirect_mem) begin
                e_fd = N; e_de = N; e_em = N; e_mw = E; e_pc = 1'b1; e_flush = 1'b1;
            end else if (lu) begin
                e_fd = S; e_de = N; e_em = E; e_mw = E; e_pc = 1'b0;
            end else if (!bus.ihit) begin
                e_fd = N; e_de = E; e_em = E; e_mw = E; e_pc = 1'b0;
            end else set_all(E, 1'b1);
        end
    endtask

    task automatic step();
        #1;
        eval_model();
        chk("fd_state", 32'(bus.fd_state), 32'(e_fd));
        chk("de_state", 32'(bus.de_state), 32'(e_de));
        chk("em_state", 32'(bus.em_state), 32'(e_em));
        chk("mw_state", 32'(bus.mw_state), 32'(e_mw));
        chk("pc_en", 32'(bus.pc_en), 32'(e_pc));
        if (mode != 2) begin
            if (!e_pc && e_next != 2) m_stall = m_stall + 1;
            if (e_flush) m_flush = m_flush + 1;
        end
        if (e_next == 2) m_halt = 1'b1;
        mode = e_next;
        @(posedge CLK);
        #1;
        chk("halt", 32'(bus.halt), 32'(m_halt));
        chk("stall_cnt", bus.stall_cnt, m_stall);
        chk("flush_cnt", bus.flush_cnt, m_flush);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        mode = 0; m_halt = 1'b0; m_stall = '0; m_flush = '0;
        chk("rst_halt", 32'(bus.halt), 32'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
        chk("rst_flush_cnt", bus.flush_cnt, 32'd0);
        RST = 1'b0;
    endtask

    task automatic idle();
        bus.ihit = 1'b1; bus.dhit = 1'b0; bus.dREN_mem = 1'b0; bus.dWEN_mem = 1'b0;
        bus.MemRead_ex = 1'b0; bus.regWSEL_ex = '0; bus.rs_id = '0; bus.rt_id = '0;
        bus.uses_rt_id = 1'b0; bus.pc_redirect_mem = 1'b0; bus.halt_wb = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();
        step();

        // data wait: three stalled cycles, then completion
        do_reset();
        bus.dREN_mem = 1'b1;
        repeat (3) step();
        bus.dhit = 1'b1;
        step();
        chk("dwait_stall_total", bus.stall_cnt, 32'd3);
        idle();
        step();

        // load-use variants
        bus.MemRead_ex = 1'b1; bus.regWSEL_ex = 5'd5; bus.rs_id = 5'd5;
        step();
        bus.regWSEL_ex = 5'd0; bus.rs_id = 5'd0;
        step();
        bus.regWSEL_ex = 5'd5; bus.rs_id = 5'd1; bus.rt_id = 5'd5; bus.uses_rt_id = 1'b0;
        step();
        bus.uses_rt_id = 1'b1;
        step();

        // redirect beats load-use
        do_reset();
        bus.rs_id = 5'd5; bus.pc_redirect_mem = 1'b1;
        step();
        chk("redirect_flush_total", bus.flush_cnt, 32'd1);

        // halt drain and freeze
        idle();
        bus.halt_wb = 1'b1;
        step();
        bus.halt_wb = 1'b0; bus.dREN_mem = 1'b1; bus.pc_redirect_mem = 1'b1; bus.ihit = 1'b0;
        repeat (3) step();
        idle();
        do_reset();

        // store wait with fetch miss
        bus.ihit = 1'b0; bus.dWEN_mem = 1'b1;
        step();
        bus.dhit = 1'b1;
        step();

        for (int i = 0; i < 500; i++) begin
            bus.ihit            = ($urandom_range(0, 3) != 0);
            bus.dhit            = $urandom_range(0, 1) == 1;
            bus.dREN_mem        = ($urandom_range(0, 3) == 0);
            bus.dWEN_mem        = ($urandom_range(0, 3) == 0);
            bus.MemRead_ex      = $urandom_range(0, 1) == 1;
            bus.regWSEL_ex      = 5'($urandom_range(0, 3));
            bus.rs_id           = 5'($urandom_range(0, 3));
            bus.rt_id           = 5'($urandom_range(0, 3));
            bus.uses_rt_id      = $urandom_range(0, 1) == 1;
            bus.pc_redirect_mem = ($urandom_range(0, 4) == 0);
            bus.halt_wb         = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) < 2 || (mode == 2 && $urandom_range(0, 7) == 0))
                do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage pipeline.
- Each cycle it chooses the latch command for all four inter-stage latches (fetch/decode, decode/execute, execute/mem, mem/wb) and the PC enable.
- Resolves data-memory waits, instruction-fetch misses, load-use hazards, branch/jump flushes and halt drain.
- Keeps stall and flush performance counters for the datapath and the bench.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters
- REG_W, 5, width of the register-select fields

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- ihit  in  1  instruction fetch data valid this cycle
- dhit  in  1  data access complete this cycle
- dREN_mem  in  1  load in MEM stage
- dWEN_mem  in  1  store in MEM stage
- MemRead_ex  in  1  instruction in EX is a load
- regWSEL_ex  in  REG_W  destination register of the instruction in EX
- rs_id  in  REG_W  source register rs of the instruction in ID
- rt_id  in  REG_W  source register rt of the instruction in ID
- uses_rt_id  in  1  instruction in ID reads rt
- pc_redirect_mem  in  1  taken branch or jump resolved in MEM
- halt_wb  in  1  halt instruction has reached WB
- fd_state  out  2  fetch/decode latch command (pipe_state_t)
- de_state  out  2  decode/execute latch command
- em_state  out  2  execute/mem latch command
- mw_state  out  2  mem/wb latch command
- pc_en  out  1  PC register may update
- halt  out  1  CPU halted (registered)
- stall_cnt  out  CNT_W  cycles with pc_en low, excluding HALT
- flush_cnt  out  CNT_W  redirect flushes taken

Behaviour:
- pipe_state_t encoding:
  - PIPE_ENABLE = 0: latch loads.
  - PIPE_STALL = 1: latch holds.
  - PIPE_NOP = 2: latch loads zeros (bubble).
- FSM states: RUN, DWAIT, HALT.
- Reset (async, RST=1):
  - FSM=RUN, halt=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs are evaluated from state RUN.
- Latch commands and pc_en are combinational from FSM state and current inputs, with zero latency.
- Counters and halt are registered and update on the next CLK edge.
- RUN, evaluated by priority (first match wins):
  1. halt_wb: all four latches STALL, pc_en=0. Next state HALT.
  2. (dREN_mem|dWEN_mem)&!dhit: all four latches STALL, pc_en=0. Next state DWAIT.
  3. pc_redirect_mem: fd, de and em NOP, mw ENABLE, pc_en=1. flush_cnt+1.
     - A mem access completing with dhit in the same cycle still flushes normally.
  4. Load-use: MemRead_ex & regWSEL_ex!=0 & (regWSEL_ex==rs_id | (uses_rt_id & regWSEL_ex==rt_id)).
     - fd STALL, de NOP, em and mw ENABLE, pc_en=0.
  5. !ihit: fd NOP, de, em and mw ENABLE, pc_en=0.
  6. Otherwise all four latches ENABLE, pc_en=1.
- DWAIT:
  - dhit=0: all four latches STALL, pc_en=0. ihit is ignored because the data port has priority.
  - dhit=1: evaluate RUN rules 3 to 6 this cycle. Next state RUN.
  - halt_wb cannot assert in DWAIT (WB is held). If it does, go HALT.
- HALT:
  - All four latches STALL, pc_en=0.
  - halt=1 from the first edge in HALT. It is sticky until RST.
  - Counters freeze.
- stall_cnt increments every cycle pc_en=0 and the next state is not HALT. It wraps at 2^CNT_W.
- flush_cnt wraps at 2^CNT_W.
- Register 0 never causes a load-use stall.
- RST asserted mid-DWAIT or mid-HALT returns to RUN immediately (asynchronous) and clears the counters.

Decomposition:
- Add to cpu_types_pkg:
  - pipe_state_t (PIPE_ENABLE, PIPE_STALL, PIPE_NOP)
  - hctl_state_t (RUN, DWAIT, HALT)
  - REG_W, if not already present
- Natural sub-module: hazard_perf_counters.
  - Holds the two CNT_W counters.
  - Inputs: stall_inc, flush_inc, freeze.
- Hazard detection and the FSM stay in the top module.

Test Plan:
- Reset, then ihit=1 with no hazards → all four states PIPE_ENABLE, pc_en=1, stall_cnt=0, flush_cnt=0.
- dREN_mem=1 with dhit low for 3 cycles, then high →
  - 3 cycles of all STALL and pc_en=0;
  - 4th cycle all ENABLE;
  - stall_cnt=3, FSM back in RUN.
- MemRead_ex=1, regWSEL_ex=5, rs_id=5 → fd STALL, de NOP, em/mw ENABLE, pc_en=0.
  - Repeat with regWSEL_ex=0 → no stall.
  - Repeat with rt_id=5 and uses_rt_id=0 → no stall.
- pc_redirect_mem=1 together with the load-use condition → redirect wins: fd/de/em NOP, mw ENABLE, pc_en=1, flush_cnt=1.
- halt_wb=1 → next edge halt=1, all STALL. Further ihit/dREN_mem/pc_redirect_mem activity changes nothing and the counters freeze.
  - RST pulse → halt=0, counters 0.
- dWEN_mem=1, dhit=0 with ihit=0 → all STALL (not fd NOP).
  - Then dhit=1, ihit=0 → fd NOP, others ENABLE.
